// File: rtl/vram_arbiter.sv
// Video RAM arbiter: VGA fetches take absolute priority, CPU pixel writes queue in a FIFO.
// Optional starvation guard enabled by defining VRAM_STARVE_GUARD_EN (adds oVgaUnderrun).
module vram_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        iCpuWrReq,
    input  logic [ADDR_W-1:0]           iCpuWrAddr,
    input  logic [DATA_W-1:0]           iCpuWrData,
    output logic                        oCpuFull,
    input  logic                        iVgaRdReq,
    input  logic [ADDR_W-1:0]           iVgaRdAddr,
    output logic [DATA_W-1:0]           oVgaRdData,
    output logic                        oVgaRdValid,
    output logic [ADDR_W-1:0]           oRamAddr,
    output logic                        oRamWrEn,
    output logic [DATA_W-1:0]           oRamWrData,
    input  logic [DATA_W-1:0]           iRamRdData,
`ifdef VRAM_STARVE_GUARD_EN
    output logic                        oVgaUnderrun,
`endif
    output logic [$clog2(FIFO_DEPTH):0] oFifoCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("vram_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_CPU} gnt_t;

    gnt_t              r_state;
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_wr_en;
    logic [DATA_W-1:0] r_ram_wr_data;
    logic              r_vga_valid;
    logic [DATA_W-1:0] r_vga_data;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_force;
    logic w_gnt_vga;
    logic w_rd_dup;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push    = iCpuWrReq & ~w_full;
    assign w_gnt_vga = iVgaRdReq & ~w_force;
    assign w_pop     = ~w_gnt_vga & (r_count != '0);

`ifdef VRAM_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] r_starve;
    logic            r_rd_dup;
    logic            r_underrun;

    // Once the CPU has been refused for STARVE_LIMIT cycles, steal one slot from VGA.
    assign w_force = (r_starve == SC_W'(STARVE_LIMIT)) & (r_count != '0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_starve   <= '0;
            r_rd_dup   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (r_starve == SC_W'(STARVE_LIMIT))
                r_starve <= '0;
            else if (w_full && iCpuWrReq && w_gnt_vga)
                r_starve <= r_starve + 1'b1;
            else
                r_starve <= '0;
            r_rd_dup   <= w_force & iVgaRdReq;
            r_underrun <= r_rd_dup;
        end
    end

    assign w_rd_dup     = r_rd_dup;
    assign oVgaUnderrun = r_underrun;
`else
    assign w_force  = 1'b0;
    assign w_rd_dup = 1'b0;
`endif

    // FIFO storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= iCpuWrAddr;
            r_fifo_data[r_wr_ptr] <= iCpuWrData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state       <= GNT_NONE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_ram_addr    <= '0;
            r_ram_wr_en   <= 1'b0;
            r_ram_wr_data <= '0;
            r_vga_valid   <= 1'b0;
            r_vga_data    <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;

            // RAM data for last cycle's VGA address is on iRamRdData now.
            r_vga_valid <= (r_state == GNT_VGA) | w_rd_dup;
            if (r_state == GNT_VGA)
                r_vga_data <= iRamRdData;

            if (w_gnt_vga) begin
                r_state     <= GNT_VGA;
                r_ram_addr  <= iVgaRdAddr;
                r_ram_wr_en <= 1'b0;
            end else if (w_pop) begin
                r_state       <= GNT_CPU;
                r_ram_addr    <= r_fifo_addr[r_rd_ptr];
                r_ram_wr_data <= r_fifo_data[r_rd_ptr];
                r_ram_wr_en   <= 1'b1;
            end else begin
                r_state     <= GNT_NONE;
                r_ram_wr_en <= 1'b0;
            end
        end
    end

    assign oCpuFull    = w_full;
    assign oFifoCount  = r_count;
    assign oRamAddr    = r_ram_addr;
    assign oRamWrEn    = r_ram_wr_en;
    assign oRamWrData  = r_ram_wr_data;
    assign oVgaRdValid = r_vga_valid;
    assign oVgaRdData  = r_vga_data;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: per-cycle vector table plus a write/read scoreboard and
// hand-written reset and starvation-guard sequences against a behavioural RAM.
module tb_vram_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 3;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_full;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_valid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [2:0]    fifo_cnt;
`ifdef VRAM_STARVE_GUARD_EN
    logic          vga_underrun;
`endif

    vram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(4)
    ) dut (
        .Clock(clk), .Reset(rst),
        .iCpuWrReq(cpu_req), .iCpuWrAddr(cpu_addr), .iCpuWrData(cpu_data),
        .oCpuFull(cpu_full),
        .iVgaRdReq(vga_req), .iVgaRdAddr(vga_addr),
        .oVgaRdData(vga_data), .oVgaRdValid(vga_valid),
        .oRamAddr(ram_addr), .oRamWrEn(ram_we), .oRamWrData(ram_wdata),
        .iRamRdData(ram_rdata),
`ifdef VRAM_STARVE_GUARD_EN
        .oVgaUnderrun(vga_underrun),
`endif
        .oFifoCount(fifo_cnt)
    );

    // Behavioural video RAM: synchronous write, read data for oRamAddr one cycle after the grant.
    logic [DW-1:0] mem [2**AW];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        else if (pre_we)
            mem[pre_addr] <= pre_data;
    end
    assign ram_rdata = mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          creq;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cdata;
        logic          vreq;
        logic [AW-1:0] vaddr;
        logic          efull;
        int            ecnt;
        logic          ewren;
    } vec_t;

    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    int            m_cnt;
    bit            mon_en;
    int            checks;
    int            errors;
    vec_t          tbl[21];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Record expectations for the stimulus now on the inputs, clock once, then score outputs.
    task automatic step();
        bit  push_ok;
        bit  pop_ok;
        wr_t e;
        wr_t g;
        push_ok = cpu_req && (m_cnt < DEPTH);
        pop_ok  = !vga_req && (m_cnt > 0);
        if (push_ok) begin
            e.addr = cpu_addr;
            e.data = cpu_data;
            wq.push_back(e);
        end
        if (vga_req)
            rq.push_back(mem[vga_addr]);
        m_cnt = m_cnt + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (ram_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_write: unexpected RAM write addr=%0h data=%0d", ram_addr, ram_wdata);
                end else begin
                    g = wq.pop_front();
                    chk("sb_wr_addr", int'(ram_addr), int'(g.addr));
                    chk("sb_wr_data", int'(ram_wdata), int'(g.data));
                end
            end
            if (vga_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_read: unexpected VGA valid data=%0d", vga_data);
                end else begin
                    chk("sb_rd_data", int'(vga_data), int'(rq.pop_front()));
                end
            end
            chk("sb_count", int'(fifo_cnt), m_cnt);
            chk("sb_full", int'(cpu_full), (m_cnt == DEPTH) ? 1 : 0);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_cnt    = 0;
        mon_en   = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        cpu_data = '0;
        vga_req  = 1'b0;
        vga_addr = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;

        // Test 3 rows 0-9: fill while VGA owns the RAM, drop the 5th push, then drain.
        tbl[0]  = '{1'b1, 15'h100, 3'd1, 1'b1, 15'd1, 1'b0, 1, 1'b0};
        tbl[1]  = '{1'b1, 15'h101, 3'd2, 1'b1, 15'd1, 1'b0, 2, 1'b0};
        tbl[2]  = '{1'b1, 15'h102, 3'd3, 1'b1, 15'd1, 1'b0, 3, 1'b0};
        tbl[3]  = '{1'b1, 15'h103, 3'd4, 1'b1, 15'd1, 1'b1, 4, 1'b0};
        tbl[4]  = '{1'b1, 15'h104, 3'd5, 1'b1, 15'd1, 1'b1, 4, 1'b0};
        tbl[5]  = '{1'b0, 15'h000, 3'd0, 1'b0, 15'd0, 1'b0, 3, 1'b1};
        tbl[6]  = '{1'b0, 15'h000, 3'd0, 1'b0, 15'd0, 1'b0, 2, 1'b1};
        tbl[7]  = '{1'b0, 15'h000, 3'd0, 1'b0, 15'd0, 1'b0, 1, 1'b1};
        tbl[8]  = '{1'b0, 15'h000, 3'd0, 1'b0, 15'd0, 1'b0, 0, 1'b1};
        tbl[9]  = '{1'b0, 15'h000, 3'd0, 1'b0, 15'd0, 1'b0, 0, 1'b0};
        // Test 4 rows 10-20: push while full and popping is dropped, the retry is accepted.
        tbl[10] = '{1'b1, 15'h200, 3'd6, 1'b1, 15'd2, 1'b0, 1, 1'b0};
        tbl[11] = '{1'b1, 15'h201, 3'd7, 1'b1, 15'd2, 1'b0, 2, 1'b0};
        tbl[12] = '{1'b1, 15'h202, 3'd1, 1'b1, 15'd2, 1'b0, 3, 1'b0};
        tbl[13] = '{1'b1, 15'h203, 3'd2, 1'b1, 15'd2, 1'b1, 4, 1'b0};
        tbl[14] = '{1'b1, 15'h204, 3'd3, 1'b0, 15'd0, 1'b0, 3, 1'b1};
        tbl[15] = '{1'b1, 15'h205, 3'd4, 1'b1, 15'd3, 1'b1, 4, 1'b0};
        tbl[16] = '{1'b0, 15'h000, 3'd0, 1'b0, 15'd0, 1'b0, 3, 1'b1};
        tbl[17] = '{1'b0, 15'h000, 3'd0, 1'b0, 15'd0, 1'b0, 2, 1'b1};
        tbl[18] = '{1'b0, 15'h000, 3'd0, 1'b0, 15'd0, 1'b0, 1, 1'b1};
        tbl[19] = '{1'b0, 15'h000, 3'd0, 1'b0, 15'd0, 1'b0, 0, 1'b1};
        tbl[20] = '{1'b0, 15'h000, 3'd0, 1'b0, 15'd0, 1'b0, 0, 1'b0};

        // Reset state
        rst = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count", int'(fifo_cnt), 0);
        chk("rst_full", int'(cpu_full), 0);
        chk("rst_wren", int'(ram_we), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_wdata", int'(ram_wdata), 0);
        chk("rst_valid", int'(vga_valid), 0);
        chk("rst_rdata", int'(vga_data), 0);
        rst = 1'b0;

        // Preload pixels 1,2,3 with 5,6,7 while the arbiter is idle
        for (int k = 1; k <= 3; k++) begin
            pre_we   = 1'b1;
            pre_addr = AW'(k);
            pre_data = DW'(k + 4);
            step();
        end
        pre_we = 1'b0;

        // Test 1: single push reaches RAM two cycles after it was driven
        cpu_req  = 1'b1;
        cpu_addr = 15'h0010;
        cpu_data = 3'b100;
        step();
        chk("t1_wren_c1", int'(ram_we), 0);
        chk("t1_count_c1", int'(fifo_cnt), 1);
        cpu_req = 1'b0;
        step();
        chk("t1_wren_c2", int'(ram_we), 1);
        chk("t1_addr_c2", int'(ram_addr), 16);
        chk("t1_data_c2", int'(ram_wdata), 4);
        chk("t1_count_c2", int'(fifo_cnt), 0);
        step();
        chk("t1_wren_c3", int'(ram_we), 0);

        // Test 2: back-to-back VGA fetches
        vga_req  = 1'b1;
        vga_addr = 15'd1;
        step();
        chk("t2_valid_c1", int'(vga_valid), 0);
        vga_addr = 15'd2;
        step();
        chk("t2_valid_c2", int'(vga_valid), 1);
        chk("t2_data_c2", int'(vga_data), 5);
        vga_addr = 15'd3;
        step();
        chk("t2_valid_c3", int'(vga_valid), 1);
        chk("t2_data_c3", int'(vga_data), 6);
        chk("t2_wren_c3", int'(ram_we), 0);
        vga_req = 1'b0;
        step();
        chk("t2_valid_c4", int'(vga_valid), 1);
        chk("t2_data_c4", int'(vga_data), 7);
        step();
        chk("t2_valid_c5", int'(vga_valid), 0);

        // Tests 3 and 4 from the vector table
        for (int i = 0; i < 21; i++) begin
            cpu_req  = tbl[i].creq;
            cpu_addr = tbl[i].caddr;
            cpu_data = tbl[i].cdata;
            vga_req  = tbl[i].vreq;
            vga_addr = tbl[i].vaddr;
            step();
            chk($sformatf("vec%0d_count", i), int'(fifo_cnt), tbl[i].ecnt);
            chk($sformatf("vec%0d_full", i), int'(cpu_full), int'(tbl[i].efull));
            chk($sformatf("vec%0d_wren", i), int'(ram_we), int'(tbl[i].ewren));
        end

        // Test 5: asynchronous reset with queued writes and a read in flight
        for (int k = 0; k < 3; k++) begin
            cpu_req  = 1'b1;
            cpu_addr = AW'(16'h400 + k);
            cpu_data = DW'(k + 1);
            vga_req  = 1'b1;
            vga_addr = 15'd2;
            step();
        end
        cpu_req = 1'b0;
        vga_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_count_now", int'(fifo_cnt), 0);
        chk("t5_valid_now", int'(vga_valid), 0);
        chk("t5_wren_now", int'(ram_we), 0);
        m_cnt = 0;
        wq.delete();
        rq.delete();
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_wren_after", int'(ram_we), 0);
            chk("t5_valid_after", int'(vga_valid), 0);
        end
        chk("sb_writes_left", wq.size(), 0);
        chk("sb_reads_left", rq.size(), 0);

`ifdef VRAM_STARVE_GUARD_EN
        // Test 6: full FIFO starved by VGA gets a forced write after 4 refused cycles
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_req  = 1'b1;
            cpu_addr = AW'(16'h300 + i);
            cpu_data = DW'(i + 1);
            vga_req  = 1'b1;
            vga_addr = 15'd1;
            step();
        end
        chk("t6_full", int'(cpu_full), 1);
        cpu_addr = 15'h310;
        for (int j = 1; j <= 5; j++) begin
            vga_addr = (j == 4) ? 15'd2 : ((j == 5) ? 15'd3 : 15'd1);
            step();
            if (j < 5) begin
                chk($sformatf("t6_wren_c%0d", j), int'(ram_we), 0);
            end else begin
                chk("t6_forced_wren", int'(ram_we), 1);
                chk("t6_forced_addr", int'(ram_addr), 16'h300);
                chk("t6_underrun_c5", int'(vga_underrun), 0);
                chk("t6_valid_c5", int'(vga_valid), 1);
                chk("t6_data_c5", int'(vga_data), 6);
            end
        end
        cpu_req = 1'b0;
        vga_req = 1'b0;
        step();
        chk("t6_valid_dup", int'(vga_valid), 1);
        chk("t6_underrun", int'(vga_underrun), 1);
        chk("t6_data_dup", int'(vga_data), 6);
        step();
        chk("t6_underrun_end", int'(vga_underrun), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
